// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the program counter and decode.
// Reads 1- or 2-byte instructions at the counter's current value over a
// req/ack memory port, hands them to decode over valid/ready, and steers the
// counter through its load/load_val inputs (hold, advance or jump).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   pc                      current counter value (fetch address)
//   pc_load, pc_load_val    counter control: load=0 lets the counter increment
//   mem_req, mem_addr       memory read request, address (always pc)
//   mem_ack, mem_rdata      read data valid this cycle, read data
//   zero_flag               ALU zero flag, looked at when JZ is handed off
//   ir, imm, ir_valid       instruction byte, immediate byte, valid to decode
//   ir_ready                decode accepts this cycle
//   halted                  HLT issued; sticky until reset
//
// state      | meaning
// -----------+-------------------------------------------------------------
// FETCH      | request opcode byte at pc; advance pc on ack
// FETCH_IMM  | request immediate byte of JMP/JZ at pc; advance pc on ack
// ISSUE      | present ir/imm to decode; jump or hold pc on handshake
// HALT       | HLT retired; pc frozen, no requests until reset

module fetch_unit #(
  parameter logic [3:0] JMP_OP = 4'hF,
  parameter logic [3:0] JZ_OP  = 4'hE,
  parameter logic [3:0] HLT_OP = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  output logic       pc_load,
  output logic [7:0] pc_load_val,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  input  logic       zero_flag,
  output logic [7:0] ir,
  output logic [7:0] imm,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_FETCH_IMM = 2'd1,
    S_ISSUE     = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;

  logic [3:0] rdata_op;
  logic [3:0] ir_op;
  logic       rdata_two_byte;
  logic       take_jump;
  logic       is_halt;

  assign rdata_op       = mem_rdata[7:4];
  assign ir_op          = ir_q[7:4];
  assign rdata_two_byte = (rdata_op == JMP_OP) || (rdata_op == JZ_OP);
  assign take_jump      = (ir_op == JMP_OP) || ((ir_op == JZ_OP) && zero_flag);
  // Only HLT with a zero operand halts; other operands fall through as no-ops.
  assign is_halt        = (ir_op == HLT_OP) && (ir_q[3:0] == 4'h0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          imm_d   = 8'h00;
          state_d = rdata_two_byte ? S_FETCH_IMM : S_ISSUE;
        end
      end
      S_FETCH_IMM: begin
        if (mem_ack) begin
          imm_d   = mem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ir_ready) begin
          state_d = is_halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs; pc hold is the default everywhere
  always_comb begin
    pc_load     = 1'b1;
    pc_load_val = pc;
    mem_req     = 1'b0;
    ir_valid    = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH, S_FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_load = 1'b0;
        end
      end
      S_ISSUE: begin
        ir_valid = 1'b1;
        if (ir_ready && take_jump) begin
          pc_load_val = imm_q;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
    // Reset forces the counter to 0 so the first FETCH after reset reads 0.
    if (reset) begin
      mem_req     = 1'b0;
      pc_load     = 1'b1;
      pc_load_val = 8'h00;
    end
  end

  assign mem_addr = pc;
  assign ir       = ir_q;
  assign imm      = imm_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a program counter and memory surround the DUT; an
// instruction-level model predicts each issued instruction, and a monitor
// checks every decode handshake and cycle-level pc control against it.

module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc = 8'h00;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata;
  logic       zero_flag = 1'b0;
  logic [7:0] ir;
  logic [7:0] imm;
  logic       ir_valid;
  logic       ir_ready = 1'b0;
  logic       halted;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .zero_flag   (zero_flag),
    .ir          (ir),
    .imm         (imm),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .halted      (halted)
  );

  // Program counter: increments every clock unless loaded.
  always @(posedge clk) pc <= pc_load ? pc_load_val : pc + 8'd1;

  assign mem_rdata = mem[mem_addr];

  int ack_pct = 100;
  int rdy_pct = 100;
  int zf_mode = 0;   // 0: zero_flag low, 1: high, 2: random

  always @(posedge clk) begin
    #2;
    mem_ack   = !reset && (int'($urandom_range(99)) < ack_pct);
    ir_ready  = int'($urandom_range(99)) < rdy_pct;
    zero_flag = (zf_mode == 2) ? ($urandom_range(1) == 1) : (zf_mode == 1);
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
  endtask

  // Instruction-level model: what gets issued when fetching from address a.
  typedef struct {
    logic [7:0] ir;
    logic [7:0] imm;
    logic [7:0] after;
  } exp_t;

  exp_t q[$];

  function automatic exp_t predict(logic [7:0] a);
    exp_t e;
    logic [7:0] a1;
    a1 = a + 8'd1;
    e.ir = mem[a];
    if (e.ir[7:4] == 4'hF || e.ir[7:4] == 4'hE) begin
      e.imm   = mem[a1];
      e.after = a + 8'd2;
    end else begin
      e.imm   = 8'h00;
      e.after = a1;
    end
    return e;
  endfunction

  bit         mon_en = 0;
  bit         halt_exp = 0;
  bit         stalled = 0;
  int         cyc = 0;
  int         issued = 0;
  int         hs_cyc[$];
  logic [7:0] last_ir, last_imm;
  exp_t       me;
  logic       mjmp;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      cyc++;
      chk("mem_addr", mem_addr, pc);
      if (halt_exp) begin
        chk("halt_flag", halted, 1);
        chk("halt_req", mem_req, 0);
        chk("halt_valid", ir_valid, 0);
        chk("halt_load", pc_load, 1);
        chk("halt_load_val", pc_load_val, pc);
      end else begin
        chk("halted_low", halted, 0);
        if (ir_valid) chk("req_in_issue", mem_req, 0);
      end
      if (ir_valid && stalled) begin
        chk("ir_stable", ir, last_ir);
        chk("imm_stable", imm, last_imm);
      end
      if (ir_valid && ir_ready) begin
        issued++;
        hs_cyc.push_back(cyc);
        if (q.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          me = q.pop_front();
          chk("ir", ir, me.ir);
          chk("imm", imm, me.imm);
          chk("pc_at_issue", pc, me.after);
          mjmp = (me.ir[7:4] == 4'hF) || (me.ir[7:4] == 4'hE && zero_flag);
          chk("issue_load", pc_load, 1);
          chk("issue_load_val", pc_load_val, mjmp ? me.imm : pc);
          if (me.ir == 8'h00) halt_exp = 1;
          else q.push_back(predict(mjmp ? me.imm : me.after));
        end
        stalled = 0;
      end else begin
        if (!halt_exp) begin
          chk("pc_load", pc_load, !(mem_req && mem_ack));
          if (pc_load) chk("hold_val", pc_load_val, pc);
        end
        stalled  = ir_valid;
        last_ir  = ir;
        last_imm = imm;
      end
    end
  end

  task automatic begin_reset();
    @(posedge clk);
    #1;
    mon_en = 0;
    reset  = 1;
  endtask

  task automatic end_reset();
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_load", pc_load, 1);
    chk("rst_load_val", pc_load_val, 0);
    @(posedge clk);
    #1;
    chk("rst_ir", ir, 0);
    chk("rst_imm", imm, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    q.delete();
    hs_cyc.delete();
    q.push_back(predict(8'h00));
    halt_exp = 0;
    stalled  = 0;
    cyc      = 0;
    issued   = 0;
    reset    = 0;
    mon_en   = 1;
  endtask

  task automatic wait_issues(int n, int budget, string nm);
    int c;
    int tgt;
    c   = 0;
    tgt = issued + n;
    while (issued < tgt && !halt_exp && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk({nm, "_timeout"}, c < budget, 1);
  endtask

  task automatic fill(logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] hp;

    // 1-byte instructions, ack and ready always high
    begin_reset();
    fill(8'h10);
    mem[0] = 8'h31; mem[1] = 8'h52;
    ack_pct = 100; rdy_pct = 100; zf_mode = 0;
    end_reset();
    wait_issues(2, 20, "seq");
    chk("seq_cyc0", hs_cyc.size() > 0 ? hs_cyc[0] : -1, 2);
    chk("seq_cyc1", hs_cyc.size() > 1 ? hs_cyc[1] : -1, 4);

    // JMP
    begin_reset();
    fill(8'h10);
    mem[0] = 8'hF0; mem[1] = 8'h40; mem[8'h40] = 8'h17;
    end_reset();
    wait_issues(2, 20, "jmp");
    chk("jmp_cyc0", hs_cyc.size() > 0 ? hs_cyc[0] : -1, 3);
    chk("jmp_cyc1", hs_cyc.size() > 1 ? hs_cyc[1] : -1, 5);

    // JZ not taken, then taken
    for (int z = 0; z < 2; z++) begin
      begin_reset();
      fill(8'h10);
      mem[0] = 8'hE0; mem[1] = 8'h20; mem[2] = 8'h21; mem[8'h20] = 8'h72;
      zf_mode = z;
      end_reset();
      wait_issues(2, 20, "jz");
    end
    zf_mode = 0;

    // Memory and decode stalls
    begin_reset();
    fill(8'h10);
    mem[0] = 8'h31;
    ack_pct = 0; rdy_pct = 0;
    end_reset();
    repeat (3) begin
      @(negedge clk);
      chk("stall_fetch_pc", pc, 0);
    end
    @(posedge clk);
    #1;
    ack_pct = 100;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ir_valid && c < 10);
    chk("stall_wait_valid", ir_valid, 1);
    ack_pct = 0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_valid", ir_valid, 1);
      chk("stall_issue_pc", pc, 1);
    end
    rdy_pct = 100;
    wait_issues(1, 20, "stall");
    ack_pct = 100;

    // HALT, then reset restarts
    begin_reset();
    fill(8'h10);
    mem[0] = 8'h00;
    end_reset();
    wait_issues(1, 20, "halt");
    chk("halt_reached", halt_exp, 1);
    @(negedge clk);
    hp = pc;
    repeat (20) @(negedge clk);
    chk("halt_frozen_pc", pc, hp);
    begin_reset();
    mem[0] = 8'h31;
    end_reset();
    wait_issues(2, 20, "after_halt");

    // pc=FF fetch/wrap and jump to own address
    begin_reset();
    fill(8'h10);
    mem[0] = 8'hF0; mem[1] = 8'hFF; mem[8'hFF] = 8'hF5;
    mem[8'hF0] = 8'hF0; mem[8'hF1] = 8'hF0;
    end_reset();
    wait_issues(5, 40, "bound");

    // Reset while waiting in FETCH_IMM
    begin_reset();
    fill(8'h10);
    mem[0] = 8'hE5; mem[1] = 8'h33;
    ack_pct = 100;
    end_reset();
    @(posedge clk);
    #1;
    ack_pct = 0;
    repeat (3) begin
      @(negedge clk);
      chk("fimm_pc", pc, 1);
      chk("fimm_valid", ir_valid, 0);
      chk("fimm_req", mem_req, 1);
    end
    begin_reset();
    end_reset();
    ack_pct = 100;
    wait_issues(2, 20, "fimm_resume");

    // Randomized programs and handshakes
    for (int r = 0; r < 40; r++) begin
      begin_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      ack_pct = int'($urandom_range(100, 30));
      rdy_pct = int'($urandom_range(100, 30));
      zf_mode = 2;
      end_reset();
      wait_issues(20, 2000, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
